// File: rtl/data_mem_sram_bridge_if.sv
// data_mem_sram_bridge_if
//   Bundles the gpu data-memory request/response channels: one read and one
//   write valid/ready pair per channel, with address and data lanes.
//   master : gpu side, drives requests and write data, receives ready/read data
//   slave  : memory side (the bridge), receives requests, returns ready/read data
// Signals (all per channel, channel c occupies element [c]):
//   mem_read_valid    read request, held until mem_read_ready
//   mem_read_address  read address, stable while valid
//   mem_read_ready    one-cycle completion pulse
//   mem_read_data     read data, valid with ready and held afterwards
//   mem_write_valid   write request, held until mem_write_ready
//   mem_write_address write address
//   mem_write_data    write data
//   mem_write_ready   one-cycle commit pulse
interface data_mem_sram_bridge_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data,
    output mem_write_valid,
    output mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data,
    input  mem_write_valid,
    input  mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/data_mem_sram_bridge.sv
// data_mem_sram_bridge
//   Memory-side endpoint for the gpu data-memory channels. Every channel
//   offers an independent read and write request; the 2*NUM_CHANNELS request
//   slots (R0,W0,R1,W1,...) are arbitrated round-robin onto one single-port
//   synchronous SRAM with one cycle of read latency. Each served request gets
//   exactly one ready pulse. One access takes three cycles:
//   grant (IDLE) -> SRAM access (ACCESS) -> response (RESP).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mem        slave side of the gpu data-memory channel bundle
//   sram_en    SRAM access enable (registered)
//   sram_we    SRAM write enable, 1=write 0=read (registered)
//   sram_addr  SRAM address (registered)
//   sram_wdata SRAM write data (registered)
//   sram_rdata SRAM read data, valid the cycle after a read access
//   busy       high whenever the access sequencer is not idle
module data_mem_sram_bridge #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_sram_bridge_if.slave mem,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata,
  output logic                 busy
);

  localparam int NUM_SLOTS = 2 * NUM_CHANNELS;
  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_next;

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0] eligible;
  logic [NUM_SLOTS-1:0] lock_q;
  logic [NUM_SLOTS-1:0] lock_set;

  logic [SLOT_BITS-1:0] rr_ptr_q, rr_ptr_next;
  logic                 grant_found;
  logic [SLOT_BITS-1:0] grant_slot;
  logic [CH_BITS-1:0]   grant_ch;

  logic [CH_BITS-1:0]   gnt_ch_q, gnt_ch_next;
  logic                 gnt_write_q, gnt_write_next;

  logic                 sram_en_next, sram_we_next;
  logic [ADDR_BITS-1:0] sram_addr_next;
  logic [DATA_BITS-1:0] sram_wdata_next;

  logic [NUM_CHANNELS-1:0]                read_ready_q, read_ready_next;
  logic [NUM_CHANNELS-1:0]                write_ready_q, write_ready_next;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q, read_data_next;

  assign mem.mem_read_ready  = read_ready_q;
  assign mem.mem_write_ready = write_ready_q;
  assign mem.mem_read_data   = read_data_q;
  assign busy                = (state_q != IDLE);

  // Flatten the channel requests into slot order: even slots are reads,
  // odd slots are writes, slot 2c/2c+1 belong to channel c.
  always_comb begin
    slot_valid = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      slot_valid[2*c]   = mem.mem_read_valid[c];
      slot_valid[2*c+1] = mem.mem_write_valid[c];
    end
  end

  // A locked slot has already been answered; the gpu keeps valid up for a
  // cycle after ready, and the lock stops that stale request being served twice.
  assign eligible = slot_valid & ~lock_q;

  // Round-robin pick: first eligible slot at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_slot  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_SLOTS) begin
        idx = idx - NUM_SLOTS;
      end
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_slot  = SLOT_BITS'(idx);
      end
    end
  end

  assign grant_ch = CH_BITS'(grant_slot >> 1);

  // Next-state and next-output logic. Every SRAM-facing and gpu-facing output
  // is registered; ready bits default low so each one is a single-cycle pulse.
  always_comb begin
    state_next       = state_q;
    rr_ptr_next      = rr_ptr_q;
    gnt_ch_next      = gnt_ch_q;
    gnt_write_next   = gnt_write_q;
    sram_en_next     = sram_en;
    sram_we_next     = sram_we;
    sram_addr_next   = sram_addr;
    sram_wdata_next  = sram_wdata;
    read_ready_next  = '0;
    write_ready_next = '0;
    read_data_next   = read_data_q;
    lock_set         = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          gnt_ch_next    = grant_ch;
          gnt_write_next = grant_slot[0];
          sram_en_next   = 1'b1;
          sram_we_next   = grant_slot[0];
          if (grant_slot[0]) begin
            sram_addr_next  = mem.mem_write_address[grant_ch];
            sram_wdata_next = mem.mem_write_data[grant_ch];
          end else begin
            sram_addr_next  = mem.mem_read_address[grant_ch];
          end
          if (int'(grant_slot) == NUM_SLOTS - 1) begin
            rr_ptr_next = '0;
          end else begin
            rr_ptr_next = grant_slot + 1'b1;
          end
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        // The SRAM samples en/we/addr on this edge; drop enable afterwards.
        sram_en_next = 1'b0;
        state_next   = RESP;
      end

      RESP: begin
        if (gnt_write_q) begin
          write_ready_next[gnt_ch_q] = 1'b1;
        end else begin
          read_ready_next[gnt_ch_q] = 1'b1;
          read_data_next[gnt_ch_q]  = sram_rdata;
        end
        lock_set[2*int'(gnt_ch_q) + int'(gnt_write_q)] = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any access in flight without a
  // response; the gpu still holds valid, so the request is simply re-granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gnt_ch_q      <= '0;
      gnt_write_q   <= 1'b0;
      lock_q        <= '0;
      sram_en       <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      read_ready_q  <= '0;
      write_ready_q <= '0;
      read_data_q   <= '0;
    end else begin
      state_q       <= state_next;
      rr_ptr_q      <= rr_ptr_next;
      gnt_ch_q      <= gnt_ch_next;
      gnt_write_q   <= gnt_write_next;
      lock_q        <= (lock_q & slot_valid) | lock_set;
      sram_en       <= sram_en_next;
      sram_we       <= sram_we_next;
      sram_addr     <= sram_addr_next;
      sram_wdata    <= sram_wdata_next;
      read_ready_q  <= read_ready_next;
      write_ready_q <= write_ready_next;
      read_data_q   <= read_data_next;
    end
  end

endmodule

// File: tb/tb_data_mem_sram_bridge.sv
// tb_data_mem_sram_bridge
//   Drives gpu-like requesters on every read/write slot, models the SRAM, and
//   predicts each response (slot, completion cycle, read data) from a
//   transaction-level model: one grant every three cycles, round-robin over
//   pending requests, memory contents updated in grant order.
module tb_data_mem_sram_bridge;

  localparam int ADDR_BITS    = 8;
  localparam int DATA_BITS    = 8;
  localparam int NUM_CHANNELS = 4;
  localparam int NUM_SLOTS    = 2 * NUM_CHANNELS;

  typedef struct {
    int         slot;
    int         ready_cycle;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] old;
  } exp_t;

  typedef enum int { D_GAP, D_REQ, D_HOLD } drv_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sram_en, sram_we, busy;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  // SRAM and reference model state
  logic [7:0] sram_mem  [256];
  logic [7:0] model_mem [256];
  exp_t       exp_q [$];
  int         model_ptr;
  int         free_edge;
  bit         pend [NUM_SLOTS];

  // Requester state
  drv_t       dstate [NUM_SLOTS];
  int         dcount [NUM_SLOTS];
  logic [7:0] req_addr [NUM_SLOTS];
  logic [7:0] req_data [NUM_SLOTS];
  bit         force_raise [NUM_SLOTS];
  logic [7:0] force_addr [NUM_SLOTS];
  logic [7:0] force_data [NUM_SLOTS];
  int         hold_extra;

  data_mem_sram_bridge_if #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .NUM_CHANNELS(NUM_CHANNELS)
  ) bus ();

  data_mem_sram_bridge #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .NUM_CHANNELS(NUM_CHANNELS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (bus),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous single-port SRAM, one cycle read latency
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic check_resp(int s, logic [7:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_ready: slot %0d at cycle %0d, no response expected", s, cycle);
      return;
    end
    e = exp_q.pop_front();
    if (e.slot != s || e.ready_cycle != cycle || (s % 2 == 0 && e.data !== d)) begin
      errors++;
      $display("[TB] FAIL resp: got slot %0d cycle %0d data %02h, expected slot %0d cycle %0d data %02h",
               s, cycle, d, e.slot, e.ready_cycle, e.data);
    end
  endtask

  // Monitor: every ready pulse must match the oldest predicted response
  always @(negedge clk) begin
    int nready;
    if (rst_n) begin
      nready = $countones(bus.mem_read_ready) + $countones(bus.mem_write_ready);
      if (nready > 0) begin
        checks++;
        if (nready > 1) begin
          errors++;
          $display("[TB] FAIL ready_onehot: got %0d ready bits, expected 1", nready);
        end
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (bus.mem_read_ready[c])  check_resp(2*c, bus.mem_read_data[c]);
        if (bus.mem_write_ready[c]) check_resp(2*c+1, 8'h00);
      end
    end
  end

  function automatic bit slot_ready(int s);
    return (s % 2 == 0) ? bus.mem_read_ready[s/2] : bus.mem_write_ready[s/2];
  endfunction

  task automatic set_valid(int s, logic v);
    if (s % 2 == 0) bus.mem_read_valid[s/2]  = v;
    else            bus.mem_write_valid[s/2] = v;
  endtask

  task automatic raise(int s, logic [7:0] a, logic [7:0] d);
    req_addr[s] = a;
    req_data[s] = d;
    if (s % 2 == 0) begin
      bus.mem_read_address[s/2] = a;
    end else begin
      bus.mem_write_address[s/2] = a;
      bus.mem_write_data[s/2]    = d;
    end
    set_valid(s, 1'b1);
    dstate[s] = D_REQ;
    pend[s]   = 1'b1;
  endtask

  task automatic driver_update(bit rnd);
    for (int s = 0; s < NUM_SLOTS; s++) begin
      case (dstate[s])
        D_REQ: begin
          if (slot_ready(s)) begin
            dstate[s] = D_HOLD;
            dcount[s] = 1 + ((hold_extra < 0) ? int'($urandom_range(0, 2)) : hold_extra);
          end
        end
        D_HOLD: begin
          dcount[s]--;
          if (dcount[s] == 0) begin
            set_valid(s, 1'b0);
            dstate[s] = D_GAP;
            dcount[s] = int'($urandom_range(1, 4));
          end
        end
        default: begin
          if (dcount[s] > 0) begin
            dcount[s]--;
          end else if (force_raise[s]) begin
            force_raise[s] = 1'b0;
            raise(s, force_addr[s], force_data[s]);
          end else if (rnd && $urandom_range(0, 2) == 0) begin
            raise(s, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
          end
        end
      endcase
    end
  endtask

  // Reference model: decides the grant for the coming edge
  task automatic model_step();
    exp_t e;
    int   s;
    if (cycle + 1 < free_edge) return;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      s = (model_ptr + k) % NUM_SLOTS;
      if (pend[s]) begin
        pend[s]       = 1'b0;
        e.slot        = s;
        e.ready_cycle = cycle + 3;
        e.addr        = req_addr[s];
        if (s % 2 == 1) begin
          e.old                = model_mem[e.addr];
          model_mem[e.addr]    = req_data[s];
          e.data               = req_data[s];
        end else begin
          e.old  = 8'h00;
          e.data = model_mem[e.addr];
        end
        exp_q.push_back(e);
        model_ptr = (s + 1) % NUM_SLOTS;
        free_edge = cycle + 4;
        return;
      end
    end
  endtask

  task automatic applyStimulus(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      driver_update(rnd);
      model_step();
    end
  endtask

  task automatic force_req(int s, logic [7:0] a, logic [7:0] d);
    force_raise[s] = 1'b1;
    force_addr[s]  = a;
    force_data[s]  = d;
  endtask

  // Asserts reset immediately, checks the cleared outputs, resynchronises the model
  task automatic do_reset(int n);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_sram_en", 32'(sram_en), 32'h0);
    checkOutput("rst_sram_we", 32'(sram_we), 32'h0);
    checkOutput("rst_sram_addr", 32'(sram_addr), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ready", 32'({bus.mem_read_ready, bus.mem_write_ready}), 32'h0);
    checkOutput("rst_rdata", 32'(bus.mem_read_data), 32'h0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_back();
      if (e.slot % 2 == 1) model_mem[e.addr] = e.old;
    end
    model_ptr = 0;
    free_edge = 0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if ((s % 2 == 0) ? bus.mem_read_valid[s/2] : bus.mem_write_valid[s/2]) begin
        pend[s]   = 1'b1;
        dstate[s] = D_REQ;
      end else begin
        pend[s] = 1'b0;
      end
    end
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_step();
  endtask

  initial begin
    bit stuck;
    rst_n                 = 1'b1;
    hold_extra            = 0;
    bus.mem_read_valid    = '0;
    bus.mem_write_valid   = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      dstate[s]      = D_GAP;
      dcount[s]      = 0;
      pend[s]        = 1'b0;
      force_raise[s] = 1'b0;
      req_addr[s]    = 8'h00;
      req_data[s]    = 8'h00;
    end
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      if (a < 4)  v = 8'(8'h11 * (a + 1));
      if (a == 5) v = 8'h00;
      sram_mem[a]  = v;
      model_mem[a] = v;
    end
    #2;
    do_reset(3);

    // Simultaneous read and write on channel 0 to the same address
    force_req(0, 8'h05, 8'h00);
    force_req(1, 8'h05, 8'h7E);
    applyStimulus(12, 1'b0);
    force_req(0, 8'h05, 8'h00);
    applyStimulus(12, 1'b0);
    checkOutput("t3_reread", 32'(bus.mem_read_data[0]), 32'h7E);

    // Four reads requested in the same cycle
    for (int c = 0; c < NUM_CHANNELS; c++) force_req(2*c, 8'(c), 8'h00);
    applyStimulus(20, 1'b0);
    for (int c = 0; c < NUM_CHANNELS; c++)
      checkOutput("t2_rdata", 32'(bus.mem_read_data[c]), 32'(8'h11 * (c + 1)));

    // Write on channel 0 then read back on channel 1
    force_req(1, 8'h10, 8'hA5);
    applyStimulus(8, 1'b0);
    force_req(2, 8'h10, 8'h00);
    applyStimulus(10, 1'b0);
    checkOutput("t1_rdata_hold", 32'(bus.mem_read_data[1]), 32'hA5);

    // Read held high two cycles past its ready pulse
    hold_extra = 2;
    force_req(4, 8'h09, 8'h00);
    applyStimulus(15, 1'b0);
    hold_extra = 0;

    // Reset while the channel 3 write is in its SRAM access cycle
    force_req(7, 8'h20, 8'h3C);
    applyStimulus(1, 1'b0);
    @(negedge clk);
    checkOutput("busy_in_access", 32'(busy), 32'h1);
    do_reset(2);
    applyStimulus(10, 1'b0);
    checkOutput("t5_write_reserved", 32'(dstate[7] != D_REQ), 32'h1);

    // Randomised traffic on all slots
    hold_extra = -1;
    applyStimulus(3000, 1'b1);
    applyStimulus(80, 1'b0);

    stuck = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) if (dstate[s] == D_REQ) stuck = 1'b1;
    checkOutput("drain_pending", 32'(exp_q.size()), 32'h0);
    checkOutput("drain_requests", 32'(stuck), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
